epl_bus_to_io: RTL

EPL_BUS_TO_IO -- requirements
Module: epl_bus_to_io

---
 rtl/epl_bus_pkg.sv | 6 +
 rtl/epl_sync_edge.sv | 27 ++
 rtl/epl_bus_to_io.sv | 85 ++++++++
 3 files changed

// File: rtl/epl_bus_pkg.sv
// epl_bus_pkg: shared constants and FSM state type for the EPL serial-to-parallel bridge
package epl_bus_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SYNC_STAGES = 2;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/epl_sync_edge.sv
// epl_sync_edge: one-bit input synchronizer with rise/fall detect against a registered copy
module epl_sync_edge
  import epl_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev;
  // shift the pin through the synchronizer and keep one more copy for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end
  assign o_q = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;
endmodule

// File: rtl/epl_bus_to_io.sv
// epl_bus_to_io: serial EPL slave that writes a parallel output port and reads back a parallel input port
module epl_bus_to_io
  import epl_bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EPL_SCLK,
  input  logic             EPL_SDI,
  input  logic             EPL_SLE,
  output logic             EPL_SDO,
  output logic             EPL_INT,
  input  logic [WIDTH-1:0] port_i,
  output logic [WIDTH-1:0] port_o,
  output logic             frame_err
);
  localparam int CW = $clog2(2*WIDTH);
  state_t r_state, w_state_n;
  logic w_sclk_rise, w_sclk_fall, w_sle_rise, w_sle_fall, w_sdi;
  logic w_unused_sclk_q, w_unused_sle_q, w_unused_sdi_rise, w_unused_sdi_fall;
  logic w_start, w_end, w_sle_edge;
  logic [WIDTH-1:0] r_tx, r_rx, r_port_o, r_pi1, r_pi2;
  logic [CW-1:0] r_cnt;
  logic r_int, r_err;

  epl_sync_edge u_sclk (.clk(clk), .reset(reset), .i_d(EPL_SCLK), .o_q(w_unused_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  epl_sync_edge u_sle  (.clk(clk), .reset(reset), .i_d(EPL_SLE),  .o_q(w_unused_sle_q),  .o_rise(w_sle_rise),  .o_fall(w_sle_fall));
  epl_sync_edge u_sdi  (.clk(clk), .reset(reset), .i_d(EPL_SDI),  .o_q(w_sdi),           .o_rise(w_unused_sdi_rise), .o_fall(w_unused_sdi_fall));

  assign w_start = (r_state == IDLE) && w_sle_rise;
  assign w_end = (r_state == SHIFT) && w_sle_fall;
  assign w_sle_edge = w_sle_rise | w_sle_fall;

  // frame framing: SLE rise opens a frame, SLE fall closes it
  always_comb begin
    w_state_n = w_start ? SHIFT : w_end ? IDLE : r_state;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_state_n;
  end

  // shift datapath; SLE edges take priority over a coincident SCLK edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx <= '0;
      r_rx <= '0;
      r_cnt <= '0;
      r_port_o <= '0;
      r_err <= 1'b0;
    end else if (w_start) begin
      r_tx <= port_i;
      r_cnt <= '0;
    end else if (w_end) begin
      if (r_cnt == CW'(WIDTH)) r_port_o <= r_rx;
      else r_err <= 1'b1;
    end else if (r_state == SHIFT && !w_sle_edge && w_sclk_rise) begin
      r_rx <= {r_rx[WIDTH-2:0], w_sdi};
      r_cnt <= (r_cnt == CW'(2*WIDTH-1)) ? r_cnt : r_cnt + 1'b1;
    end else if (r_state == SHIFT && !w_sle_edge && w_sclk_fall) begin
      r_tx <= {r_tx[WIDTH-2:0], 1'b0};
    end
  end

  // input change interrupt; tracking port_i through reset avoids a spurious event on release
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pi1 <= port_i;
      r_pi2 <= port_i;
      r_int <= 1'b0;
    end else begin
      r_pi1 <= port_i;
      r_pi2 <= r_pi1;
      r_int <= (r_pi1 != r_pi2) | (r_int & ~w_start);
    end
  end

  assign EPL_SDO = r_tx[WIDTH-1];
  assign EPL_INT = r_int;
  assign port_o = r_port_o;
  assign frame_err = r_err;
endmodule
